// File: rtl/xadc_avg_filter_if.sv
// Sample/average bus between the XADC wrapper, the block averager and the data register.
// Carries no state and adds no latency; the interface is only wiring.
// No backpressure: a sample offered with i_sample_valid is always taken (or dropped by i_clear).
interface xadc_avg_filter_if #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 3
);
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_sample;
  logic              i_clear;
  logic [DATA_W-1:0] i_limit;
  logic [DATA_W-1:0] o_avg;
  logic              o_avg_valid;
  logic              o_busy;
  logic [LOG2_N:0]   o_count;
  logic              o_alarm;

  // Producer side: the XADC wrapper / control logic driving samples and observing the mean.
  modport master (
    output i_sample_valid,
    output i_sample,
    output i_clear,
    output i_limit,
    input  o_avg,
    input  o_avg_valid,
    input  o_busy,
    input  o_count,
    input  o_alarm
  );

  // Averager side.
  modport slave (
    input  i_sample_valid,
    input  i_sample,
    input  i_clear,
    input  i_limit,
    output o_avg,
    output o_avg_valid,
    output o_busy,
    output o_count,
    output o_alarm
  );
endinterface

// File: rtl/xadc_avg_filter.sv
// Block averager: sums 2**LOG2_N accepted XADC codes and emits their truncated mean.
// Latency: o_avg/o_avg_valid appear one cycle after the N-th sample is accepted.
// No backpressure: every valid sample is consumed; i_clear flushes and drops a coincident sample.
// Optional build macro AVG_ALARM_EN enables the sticky over-limit alarm (otherwise o_alarm is 0).
module xadc_avg_filter #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 3
) (
  input logic               clk,
  input logic               rst,
  xadc_avg_filter_if.slave  bus
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] avg_q;
  logic              avg_vld_q;

  // A sample only counts when it is not flushed by a same-cycle clear.
  logic take;
  assign take = bus.i_sample_valid & ~bus.i_clear;

  logic in_acc;
  assign in_acc = (state == ACC);

  // Running sum including the sample offered now; outside ACC the sample starts a fresh block.
  logic [ACC_W-1:0] sum_in;
  logic [CNT_W-1:0] count_next;
  always_comb begin
    sum_in     = ACC_W'(bus.i_sample);
    count_next = CNT_ONE;
    if (in_acc) begin
      sum_in     = acc + ACC_W'(bus.i_sample);
      count_next = count + CNT_ONE;
    end
  end

  // This accepted sample completes the block; with N==1 every sample does.
  logic last;
  assign last = take & (in_acc ? (count == CNT_LAST) : (N == 1));

  // Truncated mean: drop the LOG2_N fraction bits, no rounding.
  logic [DATA_W-1:0] mean;
  assign mean = sum_in[ACC_W-1:LOG2_N];

`ifdef AVG_ALARM_EN
  logic alarm_q;
  logic over_limit;
  assign over_limit = (mean > bus.i_limit);
`endif

  // Block FSM: accumulate, then present the mean with a one-cycle strobe in OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
`ifdef AVG_ALARM_EN
      alarm_q   <= 1'b0;
`endif
    end else begin
      avg_vld_q <= 1'b0;
      if (bus.i_clear) begin
        // Flush the partial block; the last published mean is kept.
        state   <= IDLE;
        acc     <= '0;
        count   <= '0;
`ifdef AVG_ALARM_EN
        alarm_q <= 1'b0;
`endif
      end else if (take) begin
        acc   <= sum_in;
        count <= count_next;
        if (last) begin
          // Mean and strobe are registered together so they land in the OUT cycle.
          state     <= OUT;
          avg_q     <= mean;
          avg_vld_q <= 1'b1;
`ifdef AVG_ALARM_EN
          if (over_limit) begin
            alarm_q <= 1'b1;
          end
`endif
        end else begin
          state <= ACC;
        end
      end else if (state == OUT) begin
        // No follow-on sample: block is done, go idle with an empty count.
        state <= IDLE;
        acc   <= '0;
        count <= '0;
      end
    end
  end

  assign bus.o_avg       = avg_q;
  assign bus.o_avg_valid = avg_vld_q;
  assign bus.o_busy      = in_acc;
  assign bus.o_count     = count;

`ifdef AVG_ALARM_EN
  assign bus.o_alarm = alarm_q;
`else
  // Alarm disabled: threshold input is intentionally ignored.
  logic unused_limit;
  assign unused_limit = ^bus.i_limit;
  assign bus.o_alarm  = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_avg_filter.sv
// Directed bench for xadc_avg_filter: table-driven block vectors plus hand-written
// sequences for clear, mid-block reset and the alarm.
// Inputs change 1 time unit after the rising edge; outputs are compared at that point.
module tb_xadc_avg_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  xadc_avg_filter_if #(.DATA_W(12), .LOG2_N(3)) bus ();

  xadc_avg_filter #(.DATA_W(12), .LOG2_N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef AVG_ALARM_EN
  localparam logic EXP_ALARM = 1'b1;
`else
  localparam logic EXP_ALARM = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;

  typedef struct {
    logic        v;
    logic [11:0] s;
    logic        c;
    logic [11:0] avg;
    logic        vld;
    logic        busy;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [11:0] s, input logic c,
                              input logic [11:0] avg, input logic vld,
                              input logic busy, input logic [3:0] cnt);
    vec_t r;
    r.v = v; r.s = s; r.c = c;
    r.avg = avg; r.vld = vld; r.busy = busy; r.cnt = cnt;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] s, input logic c);
    bus.i_sample_valid = v;
    bus.i_sample       = s;
    bus.i_clear        = c;
    @(posedge clk);
    #1;
    if (bus.o_avg_valid === 1'b1) strobes++;
  endtask

  task automatic run_block(input int n, input logic [11:0] s);
    for (int k = 0; k < n; k++) step(1'b1, s, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: reset held with random inputs ----
    for (int k = 0; k < 6; k++) begin
      bus.i_sample_valid = 1'($urandom);
      bus.i_sample       = 12'($urandom);
      bus.i_clear        = 1'($urandom);
      bus.i_limit        = 12'($urandom);
      @(posedge clk);
      #1;
    end
    check("reset avg",   32'(bus.o_avg), 32'h0);
    check("reset vld",   32'(bus.o_avg_valid), 32'h0);
    check("reset busy",  32'(bus.o_busy), 32'h0);
    check("reset count", 32'(bus.o_count), 32'h0);
    check("reset alarm", 32'(bus.o_alarm), 32'h0);

    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    bus.i_clear        = 1'b0;
    bus.i_limit        = 12'hFFF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- 2/3: continuous blocks and truncation, one row per cycle ----
    for (int i = 0; i < 16; i++)
      add(1'b1, 12'h100, 1'b0, (i < 7) ? 12'h000 : 12'h100,
          (i % 8) == 7, (i % 8) != 7, 4'((i % 8) + 1));
    add(1'b0, 12'h000, 1'b0, 12'h100, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 12'(i), 1'b0, (i < 7) ? 12'h100 : 12'h003,
          i == 7, i != 7, 4'(i + 1));
    add(1'b0, 12'h000, 1'b0, 12'h003, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 12'hFFF, 1'b0, (i < 7) ? 12'h003 : 12'hFFF,
          i == 7, i != 7, 4'(i + 1));
    add(1'b0, 12'h000, 1'b0, 12'hFFF, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].c);
      check($sformatf("row%0d avg", i),   32'(bus.o_avg),       32'(vecs[i].avg));
      check($sformatf("row%0d vld", i),   32'(bus.o_avg_valid), 32'(vecs[i].vld));
      check($sformatf("row%0d busy", i),  32'(bus.o_busy),      32'(vecs[i].busy));
      check($sformatf("row%0d count", i), 32'(bus.o_count),     32'(vecs[i].cnt));
    end

    // ---- 4: gapped samples, clear mid-block, clear with valid ----
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 12'h050, 1'b0);
      step(1'b0, 12'h000, 1'b0);
      step(1'b0, 12'h000, 1'b0);
    end
    check("gap count5", 32'(bus.o_count), 32'd5);
    check("gap busy5",  32'(bus.o_busy),  32'd1);
    step(1'b0, 12'h000, 1'b1);
    check("clr count", 32'(bus.o_count), 32'd0);
    check("clr busy",  32'(bus.o_busy),  32'd0);
    check("clr avg held", 32'(bus.o_avg), 32'hFFF);
    check("clr no strobe", 32'(strobes), 32'd0);

    for (int k = 0; k < 8; k++) begin
      step(1'b1, 12'h010, 1'b0);
      if (k == 7) begin
        check("gap8 vld", 32'(bus.o_avg_valid), 32'd1);
        check("gap8 avg", 32'(bus.o_avg), 32'h010);
      end
      step(1'b0, 12'h000, 1'b0);
      step(1'b0, 12'h000, 1'b0);
    end
    check("gap8 strobes", 32'(strobes), 32'd1);

    step(1'b1, 12'h010, 1'b0);
    step(1'b1, 12'h010, 1'b0);
    check("pre clrv count", 32'(bus.o_count), 32'd2);
    step(1'b1, 12'hFFF, 1'b1);
    check("clrv count", 32'(bus.o_count), 32'd0);
    check("clrv avg held", 32'(bus.o_avg), 32'h010);
    run_block(7, 12'h008);
    check("after clrv count7", 32'(bus.o_count), 32'd7);
    check("after clrv vld7",   32'(bus.o_avg_valid), 32'd0);
    step(1'b1, 12'h008, 1'b0);
    check("after clrv vld", 32'(bus.o_avg_valid), 32'd1);
    check("after clrv avg", 32'(bus.o_avg), 32'h008);
    step(1'b0, 12'h000, 1'b0);

    // ---- 5: reset in the middle of a block ----
    run_block(4, 12'h7FF);
    check("mid count4", 32'(bus.o_count), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("async rst count", 32'(bus.o_count), 32'd0);
    check("async rst busy",  32'(bus.o_busy),  32'd0);
    check("async rst avg",   32'(bus.o_avg),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    strobes = 0;
    run_block(8, 12'h020);
    check("post rst vld", 32'(bus.o_avg_valid), 32'd1);
    check("post rst avg", 32'(bus.o_avg), 32'h020);
    check("post rst strobes", 32'(strobes), 32'd1);
    step(1'b0, 12'h000, 1'b0);

    // ---- 6: alarm ----
    bus.i_limit = 12'h800;
    check("alarm init", 32'(bus.o_alarm), 32'd0);
    run_block(7, 12'h900);
    check("alarm before strobe", 32'(bus.o_alarm), 32'd0);
    step(1'b1, 12'h900, 1'b0);
    check("alarm blk avg", 32'(bus.o_avg), 32'h900);
    check("alarm blk vld", 32'(bus.o_avg_valid), 32'd1);
    check("alarm set", 32'(bus.o_alarm), 32'(EXP_ALARM));
    run_block(8, 12'h100);
    check("alarm low avg", 32'(bus.o_avg), 32'h100);
    check("alarm sticky", 32'(bus.o_alarm), 32'(EXP_ALARM));
    step(1'b0, 12'h000, 1'b1);
    check("alarm cleared", 32'(bus.o_alarm), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
